// File: rtl/bin2gray.sv
// Binary-to-Gray converter: zero-latency combinational output plus a
// registered, valid-qualified copy suitable for feeding a CDC synchroniser.
module bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin,
  input  logic             bin_valid,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_q,
  output logic             gray_valid
);

  // Logical shift: the MSB passes straight through, every lower bit is
  // the XOR of itself and its upper neighbour.
  assign gray = bin ^ (bin >> 1);

  // Each gray_q bit is a bare flop output, so the crossing sees no glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q     <= '0;
      gray_valid <= 1'b0;
    end else begin
      gray_valid <= bin_valid;
      if (bin_valid) begin
        gray_q <= gray;
      end
    end
  end

endmodule

// File: tb/tb_bin2gray.sv
// Self-checking bench for bin2gray: table, streaming, hold, async reset,
// single-bit-change property, random back-to-back traffic and width sweep.
module tb_bin2gray;

  logic        clk;
  logic        rst_n;
  logic [3:0]  bin;
  logic        valid;
  logic [3:0]  gray;
  logic [3:0]  gray_q;
  logic        gray_valid;

  logic [0:0]  b1, g1, q1;
  logic [7:0]  b8, g8, q8;
  logic [15:0] b16, g16, q16;
  logic        vw, v1, v8, v16;

  int pass_cnt;
  int total_cnt;

  logic [3:0] tbl [16];

  bin2gray #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bin(bin), .bin_valid(valid),
    .gray(gray), .gray_q(gray_q), .gray_valid(gray_valid)
  );

  bin2gray #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .bin(b1), .bin_valid(vw),
    .gray(g1), .gray_q(q1), .gray_valid(v1)
  );

  bin2gray #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .bin(b8), .bin_valid(vw),
    .gray(g8), .gray_q(q8), .gray_valid(v8)
  );

  bin2gray #(.WIDTH(16)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .bin(b16), .bin_valid(vw),
    .gray(g16), .gray_q(q16), .gray_valid(v16)
  );

  always #5 clk = ~clk;

  // Reference built from the per-bit rule: MSB copied, others neighbour XOR.
  function automatic logic [15:0] ref_gray(input logic [15:0] b, input int w);
    logic [15:0] g;
    g = '0;
    for (int i = 0; i < w; i++) begin
      if (i == w - 1) g[i] = b[i];
      else            g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  task automatic test_reset;
    #2;
    bin = 4'd5;
    #1;
    total_cnt++;
    if (gray_q !== 4'b0000 || gray_valid !== 1'b0)
      $display("FAIL reset_state: gray_q=%b gray_valid=%b required 0000/0", gray_q, gray_valid);
    else pass_cnt++;
    total_cnt++;
    if (gray !== 4'b0111)
      $display("FAIL comb_in_reset: gray=%b required 0111", gray);
    else pass_cnt++;
    total_cnt++;
    if (q16 !== 16'h0000 || v8 !== 1'b0)
      $display("FAIL reset_wide: q16=%h v8=%b required 0000/0", q16, v8);
    else pass_cnt++;
  endtask

  task automatic test_comb_exhaustive;
    for (int b = 0; b < 16; b++) begin
      bin = 4'(b);
      #1;
      total_cnt++;
      if (gray !== tbl[b])
        $display("FAIL comb_table bin=%0d: gray=%b required %b", b, gray, tbl[b]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stream;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      rst_n = 1'b1;
      bin   = 4'(b);
      valid = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++;
      if (gray_q !== tbl[b] || gray_valid !== 1'b1)
        $display("FAIL stream bin=%0d: gray_q=%b valid=%b required %b/1", b, gray_q, gray_valid, tbl[b]);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    bin = 4'd9; valid = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (gray_q !== 4'b1101 || gray_valid !== 1'b1)
      $display("FAIL hold_load: gray_q=%b valid=%b required 1101/1", gray_q, gray_valid);
    else pass_cnt++;
    @(negedge clk);
    bin = 4'd3; valid = 1'b0;
    #1;
    total_cnt++;
    if (gray !== 4'b0010)
      $display("FAIL hold_comb: gray=%b required 0010", gray);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (gray_q !== 4'b1101 || gray_valid !== 1'b0)
      $display("FAIL hold_keep: gray_q=%b valid=%b required 1101/0", gray_q, gray_valid);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bin = 4'd15; valid = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (gray_q !== 4'b1000)
      $display("FAIL areset_pre: gray_q=%b required 1000", gray_q);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (gray_q !== 4'b0000 || gray_valid !== 1'b0)
      $display("FAIL areset_immediate: gray_q=%b valid=%b required 0000/0", gray_q, gray_valid);
    else pass_cnt++;
    bin = 4'd6;
    #1;
    total_cnt++;
    if (gray !== 4'b0101)
      $display("FAIL areset_comb: gray=%b required 0101", gray);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (gray_q !== 4'b0000 || gray_valid !== 1'b0)
      $display("FAIL areset_held: gray_q=%b valid=%b required 0000/0", gray_q, gray_valid);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
  endtask

  task automatic test_wrap;
    logic [3:0] prev;
    logic [3:0] expv;
    valid = 1'b1;
    for (int s = 0; s < 34; s++) begin
      @(negedge clk);
      bin = (s == 0) ? 4'd15 : 4'((s - 1) % 16);
      #1;
      expv = 4'(ref_gray(16'(bin), 4));
      total_cnt++;
      if (gray !== expv)
        $display("FAIL wrap_value bin=%0d: gray=%b required %b", bin, gray, expv);
      else pass_cnt++;
      if (s > 0) begin
        total_cnt++;
        if ($countones(gray ^ prev) != 1)
          $display("FAIL wrap_one_bit bin=%0d: %b -> %b changed %0d bits required 1",
                   bin, prev, gray, $countones(gray ^ prev));
        else pass_cnt++;
      end
      prev = gray;
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_q;
    logic       exp_v;
    logic [3:0] expc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      bin   = 4'($urandom);
      valid = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      expc = 4'(ref_gray(16'(bin), 4));
      total_cnt++;
      if (gray !== expc)
        $display("FAIL rand_comb bin=%0d: gray=%b required %b", bin, gray, expc);
      else pass_cnt++;
      @(posedge clk);
      if (valid) exp_q = expc;
      exp_v = valid;
      #1;
      total_cnt++;
      if (gray_q !== exp_q || gray_valid !== exp_v)
        $display("FAIL rand_reg cycle=%0d: gray_q=%b valid=%b required %b/%b",
                 i, gray_q, gray_valid, exp_q, exp_v);
      else pass_cnt++;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_width_sweep;
    logic [0:0]  e1, eq1;
    logic [7:0]  e8, eq8;
    logic [15:0] e16, eq16;
    logic        ev;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      b1  = 1'($urandom);
      b8  = 8'($urandom);
      b16 = 16'($urandom);
      vw  = (i == 0) ? 1'b1 : 1'($urandom);
      #1;
      e1  = 1'(ref_gray(16'(b1), 1));
      e8  = 8'(ref_gray(16'(b8), 8));
      e16 = ref_gray(b16, 16);
      total_cnt++;
      if (g1 !== e1 || g8 !== e8 || g16 !== e16)
        $display("FAIL sweep_comb: g1=%b g8=%h g16=%h required %b %h %h", g1, g8, g16, e1, e8, e16);
      else pass_cnt++;
      total_cnt++;
      if (g1[0] !== b1[0] || g8[7] !== b8[7] || g16[15] !== b16[15])
        $display("FAIL sweep_msb: msbs %b%b%b required %b%b%b", g1[0], g8[7], g16[15], b1[0], b8[7], b16[15]);
      else pass_cnt++;
      @(posedge clk);
      if (vw) begin
        eq1 = e1; eq8 = e8; eq16 = e16;
      end
      ev = vw;
      #1;
      total_cnt++;
      if (q1 !== eq1 || q8 !== eq8 || q16 !== eq16 || v1 !== ev || v8 !== ev || v16 !== ev)
        $display("FAIL sweep_reg cycle=%0d: q=%b %h %h v=%b%b%b required %b %h %h v=%b",
                 i, q1, q8, q16, v1, v8, v16, eq1, eq8, eq16, ev);
      else pass_cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    pass_cnt = 0; total_cnt = 0;
    clk = 1'b0; rst_n = 1'b0; bin = '0; valid = 1'b0;
    b1 = '0; b8 = '0; b16 = '0; vw = 1'b0;

    test_reset;
    test_comb_exhaustive;
    test_stream;
    test_hold;
    test_async_reset;
    test_wrap;
    test_back_to_back;
    test_width_sweep;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
